cordic_seq_ctrl: RTL and testbench

- Sequencing controller for the iterative CORDIC datapath (x/y/z registers fed through 8-bit signed 2:1 muxes).
- Accepts a start request and drives mux select to load the initial operands, then feedback for ITER iterations.
- Per iteration, supplies the iteration index (shift amount / arctan ROM address) and the rotation direction, then pulses done.
- Sits between the top-level request logic and the CORDIC register/mux datapath.

---
 rtl/cordic_ctrl_pkg.sv | 20 ++
 rtl/cordic_iter_cnt.sv | 42 ++++
 rtl/cordic_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC sequencing controller.
// Optional abort support in the top is enabled by CORDIC_SEQ_ABORT_EN.
package cordic_ctrl_pkg;

    // Default number of micro-rotations per operation.
    localparam int ITER_DEF = 8;

    // Operating mode encoding, latched on start.
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ITERATE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration index counter: sync clear, enable, terminal-count flag at ITER-1.
// Wraps to 0 after the terminal count, so the index never exceeds ITER-1.
module cordic_iter_cnt
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = $clog2(ITER)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == CNT_W'(ITER - 1));
    assign cnt_o = cnt_q;

    // Next count: clear has priority, terminal count rolls back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// CORDIC sequencing controller: loads initial operands, runs ITER feedback
// iterations supplying index and rotation direction, then pulses done.
// Define CORDIC_SEQ_ABORT_EN to add the abort_in port.
module cordic_seq_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = $clog2(ITER)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic             z_sign_in,
    input  logic             y_sign_in,
`ifdef CORDIC_SEQ_ABORT_EN
    input  logic             abort_in,
`endif
    output logic             sel_out,
    output logic             load_en_out,
    output logic [CNT_W-1:0] iter_out,
    output logic             dir_out,
    output logic             busy_out,
    output logic             done_out
);

    state_e           state_q;
    state_e           state_d;
    logic             mode_q;
    logic             mode_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             abort_w;

`ifdef CORDIC_SEQ_ABORT_EN
    assign abort_w = abort_in;
`else
    assign abort_w = 1'b0;
`endif

    cordic_iter_cnt #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // State and latched mode registers; reset dominates start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            mode_q  <= MODE_ROT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        sel_out     = 1'b0;
        load_en_out = 1'b0;
        iter_out    = '0;
        dir_out     = 1'b0;
        busy_out    = 1'b0;
        done_out    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = LOAD;
                    mode_d  = mode_in;
                end
            end
            LOAD: begin
                busy_out    = 1'b1;
                load_en_out = 1'b1;
                cnt_clr     = 1'b1;
                state_d     = ITERATE;
                // Aborting suppresses the write so the datapath is left untouched.
                if (abort_w) begin
                    load_en_out = 1'b0;
                    state_d     = IDLE;
                end
            end
            ITERATE: begin
                busy_out    = 1'b1;
                sel_out     = 1'b1;
                load_en_out = 1'b1;
                iter_out    = cnt;
                dir_out     = (mode_q == MODE_VEC) ? ~y_sign_in : z_sign_in;
                cnt_en      = 1'b1;
                if (cnt_tc) begin
                    state_d = DONE;
                end
                if (abort_w) begin
                    load_en_out = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl (default build, ITER=8).
module tb_cordic_seq_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic       mode_in;
    logic       z_sign_in;
    logic       y_sign_in;
    logic       sel_out;
    logic       load_en_out;
    logic [2:0] iter_out;
    logic       dir_out;
    logic       busy_out;
    logic       done_out;

    cordic_seq_ctrl dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .mode_in     (mode_in),
        .z_sign_in   (z_sign_in),
        .y_sign_in   (y_sign_in),
        .sel_out     (sel_out),
        .load_en_out (load_en_out),
        .iter_out    (iter_out),
        .dir_out     (dir_out),
        .busy_out    (busy_out),
        .done_out    (done_out)
    );

    always #5 clk_in = ~clk_in;

    // One operation: mode, per-iteration sign inputs, expected dir per iteration.
    typedef struct packed {
        logic       mode;
        logic [7:0] z;
        logic [7:0] y;
        logic [7:0] dir;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] exp_q [$];
    int         errs   = 0;
    int         checks = 0;

    // Packed expectation: {sel, load_en, iter[2:0], dir, busy, done}
    function automatic logic [7:0] pk(input logic sel, input logic ld, input logic [2:0] it,
                                      input logic dir, input logic busy, input logic done);
        return {sel, ld, it, dir, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm);
        logic [7:0] act;
        logic [7:0] e;
        #1;
        act = {sel_out, load_en_out, iter_out, dir_out, busy_out, done_out};
        checks++;
        if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty, got %b", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errs++;
                $display("FAIL %s: got %b expected %b (sel,ld,iter,dir,busy,done)", nm, act, e);
            end
        end
    endtask

    task automatic idle_cycle(input string nm);
        exp_q.push_back(8'h00);
        chk(nm);
    endtask

    // Full operation; mid_start re-asserts start at iteration 3 (must be ignored).
    task automatic run_op(input vec_t v, input bit mid_start, input int id);
        tick();
        start_in = 1'b1; mode_in = v.mode; z_sign_in = 1'b0; y_sign_in = 1'b0;
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 0));
        exp_q.push_back(pk(0, 1, 3'd0, 0, 1, 0));
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(1, 1, 3'(i), v.dir[i], 1, 0));
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 1));
        chk($sformatf("op%0d_pre", id));
        tick();
        start_in = 1'b0;
        chk($sformatf("op%0d_load", id));
        for (int i = 0; i < 8; i++) begin
            tick();
            z_sign_in = v.z[i];
            y_sign_in = v.y[i];
            mode_in   = ~v.mode;
            start_in  = mid_start && (i == 3);
            chk($sformatf("op%0d_iter%0d", id, i));
        end
        tick();
        start_in = 1'b0;
        chk($sformatf("op%0d_done", id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mode: 1'b0, z: 8'hAA, y: 8'h00, dir: 8'hAA};
        tbl[1] = '{mode: 1'b0, z: 8'h0F, y: 8'hFF, dir: 8'h0F};
        tbl[2] = '{mode: 1'b1, z: 8'h5A, y: 8'h00, dir: 8'hFF};
        tbl[3] = '{mode: 1'b1, z: 8'h00, y: 8'hFF, dir: 8'h00};
        tbl[4] = '{mode: 1'b1, z: 8'hFF, y: 8'h35, dir: 8'hCA};
        tbl[5] = '{mode: 1'b0, z: 8'hFF, y: 8'h00, dir: 8'hFF};

        rst_in = 1'b1; start_in = 1'b0; mode_in = 1'b0; z_sign_in = 1'b0; y_sign_in = 1'b0;

        // Reset for two cycles, then quiet idle.
        tick(); idle_cycle("rst0");
        tick(); idle_cycle("rst1");
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); z_sign_in = i[0]; y_sign_in = ~i[0];
            idle_cycle($sformatf("idle%0d", i));
        end

        // Table-driven operations; op 2 also gets a start while busy.
        for (int k = 0; k < 6; k++) run_op(tbl[k], (k == 2), k);

        // Start held high through DONE: new op only after an IDLE cycle.
        tick();
        start_in = 1'b1; mode_in = 1'b0; z_sign_in = 1'b1; y_sign_in = 1'b0;
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 0));
        exp_q.push_back(pk(0, 1, 3'd0, 0, 1, 0));
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(1, 1, 3'(i), 1, 1, 0));
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 1));
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 0));
        exp_q.push_back(pk(0, 1, 3'd0, 0, 1, 0));
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            chk($sformatf("hold%0d", i));
        end
        start_in = 1'b0; z_sign_in = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(1, 1, 3'(i), 0, 1, 0));
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 1));
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("hold_tail%0d", i));
        end

        // Reset during iteration 5: straight to IDLE, no done pulse.
        tick();
        start_in = 1'b1; mode_in = 1'b0; z_sign_in = 1'b0;
        exp_q.push_back(pk(0, 0, 3'd0, 0, 0, 0));
        exp_q.push_back(pk(0, 1, 3'd0, 0, 1, 0));
        for (int i = 0; i < 6; i++) exp_q.push_back(pk(1, 1, 3'(i), 1, 1, 0));
        chk("mrst_pre");
        tick(); start_in = 1'b0; chk("mrst_load");
        for (int i = 0; i < 6; i++) begin
            tick(); z_sign_in = 1'b1; rst_in = (i == 5);
            chk($sformatf("mrst_iter%0d", i));
        end
        tick(); rst_in = 1'b0; z_sign_in = 1'b0; idle_cycle("mrst_idle0");
        for (int i = 1; i < 4; i++) begin
            tick(); idle_cycle($sformatf("mrst_idle%0d", i));
        end
        run_op(tbl[1], 1'b0, 6);

        // Reset and start in the same cycle: reset wins.
        tick(); rst_in = 1'b1; start_in = 1'b1; mode_in = 1'b1; idle_cycle("rs_same0");
        tick(); rst_in = 1'b0; start_in = 1'b0; idle_cycle("rs_same1");
        tick(); idle_cycle("rs_same2");

        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
